apb_bus_arbiter: RTL

- APB master-side controller that shares one APB bus among NUM_REQ on-chip requesters (e.g. CPU bridge, DMA).
- Accepts single-word requests and arbitrates them round-robin.
- Sequences each APB transfer through its SETUP and ACCESS phases and decodes the per-slave PSEL from the address.
- Returns read data and error status to the winning requester with a one-cycle done pulse; it drives peripheral slave interfaces such as the timer's.

---
 rtl/apb_bus_arbiter.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/apb_bus_arbiter.sv
// apb_bus_arbiter
//   APB master-side controller that shares one APB bus among NUM_REQ
//   requesters. Requests are arbitrated round-robin, each transfer runs
//   SETUP -> ACCESS, and the per-slave PSEL is decoded from the address.
//   Read data and error status go back to the winner with a one-cycle
//   done pulse.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   n_rst      : synchronous active-low reset
//   req        : per-requester request, held until its done
//   req_addr   : packed NUM_REQ x 32 request addresses (requester i at [32*i +: 32])
//   req_write  : per-requester direction, 1 = write
//   req_wdata  : packed NUM_REQ x 32 write data
//   done       : one-hot completion pulse
//   rdata      : read data, valid while done is high
//   err        : error response, valid while done is high
//   PADDR, PWDATA, PWRITE, PENABLE, PSEL : APB master outputs
//   PRDATA     : packed NUM_SLAVES x 32 per-slave read data
//   PSLVERR    : per-slave error
module apb_bus_arbiter #(
  parameter int          NUM_REQ     = 2,
  parameter int          NUM_SLAVES  = 4,
  parameter int          SEL_LSB     = 12,
  parameter logic [31:0] DECERR_DATA = 32'hBAD1BAD1
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*32-1:0]      req_addr,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*32-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]         done,
  output logic [31:0]                rdata,
  output logic                       err,
  output logic [31:0]                PADDR,
  output logic [31:0]                PWDATA,
  output logic                       PWRITE,
  output logic                       PENABLE,
  output logic [NUM_SLAVES-1:0]      PSEL,
  input  logic [NUM_SLAVES*32-1:0]   PRDATA,
  input  logic [NUM_SLAVES-1:0]      PSLVERR
);

  // A single slave still needs a one-bit select register internally; the
  // address field is then ignored and the select is forced to 0.
  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [SEL_W:0] NUM_SLAVES_W = (SEL_W + 1)'(NUM_SLAVES);
  localparam logic [IDX_W:0] NUM_REQ_W    = (IDX_W + 1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_REQ   = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       gnt_q, gnt_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [NUM_SLAVES-1:0]  psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic [31:0]            paddr_q, paddr_d;
  logic [31:0]            pwdata_q, pwdata_d;
  logic                   pwrite_q, pwrite_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   err_q, err_d;

  // Unpacked views of the packed per-requester / per-slave buses
  logic [31:0] req_addr_a  [NUM_REQ];
  logic [31:0] req_wdata_a [NUM_REQ];
  logic [31:0] prdata_a    [NUM_SLAVES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req_unpack
      assign req_addr_a[gi]  = req_addr[gi*32 +: 32];
      assign req_wdata_a[gi] = req_wdata[gi*32 +: 32];
    end
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slv_unpack
      assign prdata_a[gi] = PRDATA[gi*32 +: 32];
    end
  endgenerate

  // ------------------------------------------------------------------
  // Round-robin arbitration: rotate req so rr_ptr lands on bit 0, pick the
  // lowest set bit, then rotate the offset back to an absolute index.
  // ------------------------------------------------------------------
  logic [NUM_REQ-1:0] req_rot;
  logic [IDX_W-1:0]   gnt_off;
  logic [IDX_W:0]     gnt_sum;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic [IDX_W-1:0]   rr_ptr_next;

  always_comb begin
    req_rot   = NUM_REQ'({req, req} >> rr_ptr_q);
    gnt_valid = 1'b0;
    gnt_off   = '0;
    // Descending scan so the lowest set offset is the one left standing
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        gnt_valid = 1'b1;
        gnt_off   = IDX_W'(i);
      end
    end
    gnt_sum = {1'b0, rr_ptr_q} + {1'b0, gnt_off};
    if (gnt_sum >= NUM_REQ_W) begin
      gnt_idx = IDX_W'(gnt_sum - NUM_REQ_W);
    end else begin
      gnt_idx = gnt_sum[IDX_W-1:0];
    end
    rr_ptr_next = (gnt_idx == LAST_REQ) ? '0 : gnt_idx + 1'b1;
  end

  // ------------------------------------------------------------------
  // Slave-select decode from the winner's address (the value being latched)
  // ------------------------------------------------------------------
  logic [31:0]           gnt_addr;
  logic [SEL_W-1:0]      sel_raw;
  logic                  dec_ok;
  logic [NUM_SLAVES-1:0] psel_onehot;

  assign gnt_addr = req_addr_a[gnt_idx];

  generate
    if (NUM_SLAVES > 1) begin : g_sel_field
      assign sel_raw = gnt_addr[SEL_LSB +: SEL_W];
    end else begin : g_sel_single
      assign sel_raw = '0;
    end
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_psel_dec
      assign psel_onehot[gi] = (sel_raw == SEL_W'(gi));
    end
  endgenerate

  // Only reachable when NUM_SLAVES is not a power of two
  assign dec_ok = ({1'b0, sel_raw} < NUM_SLAVES_W);

  // One-hot done vectors for the fresh grant and the held grant
  logic [NUM_REQ-1:0] gnt_idx_oh;
  logic [NUM_REQ-1:0] gnt_q_oh;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_gnt_oh
      assign gnt_idx_oh[gi] = (gnt_idx == IDX_W'(gi));
      assign gnt_q_oh[gi]   = (gnt_q == IDX_W'(gi));
    end
  endgenerate

  // ------------------------------------------------------------------
  // Transfer sequencer: next-state and next-output logic. Every output is
  // a flop, so each value here is what appears on the port next cycle.
  // ------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    done_d    = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        psel_d    = '0;
        penable_d = 1'b0;
        rdata_d   = '0;
        err_d     = 1'b0;
        if (gnt_valid) begin
          gnt_d    = gnt_idx;
          rr_ptr_d = rr_ptr_next;
          sel_d    = sel_raw;
          paddr_d  = gnt_addr;
          pwdata_d = req_wdata_a[gnt_idx];
          pwrite_d = req_write[gnt_idx];
          if (dec_ok) begin
            psel_d  = psel_onehot;
            state_d = SETUP;
          end else begin
            // Decode error: never touch the bus, complete straight away
            done_d  = gnt_idx_oh;
            err_d   = 1'b1;
            rdata_d = DECERR_DATA;
            state_d = DONE;
          end
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end

      ACCESS: begin
        psel_d    = '0;
        penable_d = 1'b0;
        rdata_d   = pwrite_q ? 32'h0 : prdata_a[sel_q];
        err_d     = PSLVERR[sel_q];
        done_d    = gnt_q_oh;
        state_d   = DONE;
      end

      DONE: begin
        // No grant here, so a requester has a cycle to drop its req
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      sel_q     <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PWRITE  = pwrite_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign err     = err_q;

endmodule
